// File: rtl/pc_pkg.sv
// Shared constants and next-PC select encoding for the program counter slice.
package pc_pkg;

  localparam int PC_WIDTH       = 16;
  localparam int PC_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    PC_SEL_HOLD,
    PC_SEL_INC,
    PC_SEL_LOAD,
    PC_SEL_POP,
    PC_SEL_CLEAR
  } pc_sel_t;

endpackage

// File: rtl/program_counter_ret_stack.sv
// Return-address LIFO: DEPTH x WIDTH entries with push/pop/flush and a sticky
// error flag for overflow, underflow and simultaneous push+pop.
module ret_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         top,
  output logic                     pop_ok,
  output logic [$clog2(DEPTH):0]   sp_depth,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [WIDTH-1:0] entries [DEPTH];
  logic             push_ok;
  logic             err_set;

  assign full    = (sp_depth == DW'(DEPTH));
  assign empty   = (sp_depth == '0);
  assign push_ok = push & ~pop & ~full & ~flush;
  assign pop_ok  = pop & ~push & ~empty & ~flush;
  assign err_set = (push & pop) | (push & full) | (pop & empty);

  // Index wraps when empty; the value is never selected in that case.
  assign top = entries[AW'(sp_depth - DW'(1))];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_depth <= '0;
      err      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      sp_depth <= '0;
      err      <= 1'b0;
    end else begin
      if (err_set) err <= 1'b1;
      if (push_ok) begin
        entries[AW'(sp_depth)] <= din;
        sp_depth               <= sp_depth + DW'(1);
      end else if (pop_ok) begin
        sp_depth <= sp_depth - DW'(1);
      end
    end
  end

endmodule

// File: rtl/program_counter.sv
// Hack program counter with call/return stack. Optional watchpoint comparator
// is built when PC_WATCHPOINT_EN is defined.
module program_counter
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = PC_STACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic                   inc,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  output logic [WIDTH-1:0]       out,
  output logic [$clog2(DEPTH):0] sp_depth,
  output logic                   stack_full,
  output logic                   stack_empty,
  output logic                   stack_err
`ifdef PC_WATCHPOINT_EN
  ,
  input  logic [WIDTH-1:0]       watch_addr,
  input  logic                   watch_en,
  output logic                   watch_hit
`endif
);

  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] stack_top;
  logic             pop_ok;
  pc_sel_t          sel;

  assign pc_plus1 = out + WIDTH'(1);

  // The return address is always pre-edge out+1, whatever the PC does next.
  ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk      (clk),
    .rst      (rst),
    .flush    (clear),
    .push     (push),
    .pop      (pop),
    .din      (pc_plus1),
    .top      (stack_top),
    .pop_ok   (pop_ok),
    .sp_depth (sp_depth),
    .full     (stack_full),
    .empty    (stack_empty),
    .err      (stack_err)
  );

  always_comb begin
    sel = PC_SEL_HOLD;
    if (clear)       sel = PC_SEL_CLEAR;
    else if (pop_ok) sel = PC_SEL_POP;
    else if (load)   sel = PC_SEL_LOAD;
    else if (inc)    sel = PC_SEL_INC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else begin
      case (sel)
        PC_SEL_CLEAR: out <= '0;
        PC_SEL_POP:   out <= stack_top;
        PC_SEL_LOAD:  out <= in;
        PC_SEL_INC:   out <= pc_plus1;
        default:      out <= out;
      endcase
    end
  end

`ifdef PC_WATCHPOINT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        watch_hit <= 1'b0;
    else if (clear) watch_hit <= 1'b0;
    else            watch_hit <= watch_en & (out == watch_addr);
  end
`else
  // No watchpoint hardware in this build.
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: reference model feeds a scoreboard
// queue at drive time; entries are popped and compared after each edge.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in = '0;
  logic        load = 1'b0, inc = 1'b0, clear = 1'b0, push = 1'b0, pop = 1'b0;
  logic [15:0] out;
  logic [2:0]  sp_depth;
  logic        stack_full, stack_empty, stack_err;
  logic [15:0] watch_addr = '0;
  logic        watch_en = 1'b0;
`ifdef PC_WATCHPOINT_EN
  logic        watch_hit;
`endif

  always #5 clk = ~clk;

  program_counter dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .load        (load),
    .inc         (inc),
    .clear       (clear),
    .push        (push),
    .pop         (pop),
    .out         (out),
    .sp_depth    (sp_depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
`ifdef PC_WATCHPOINT_EN
    ,
    .watch_addr  (watch_addr),
    .watch_en    (watch_en),
    .watch_hit   (watch_hit)
`endif
  );

  typedef struct {
    logic [15:0] pc;
    logic [2:0]  sp;
    logic        err;
    logic        hit;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [15:0] m_pc;
  logic [15:0] m_stk [4];
  int          m_sp;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = '0;
    m_sp  = 0;
    m_err = 1'b0;
    for (int i = 0; i < 4; i++) m_stk[i] = '0;
  endtask

  // Drive one cycle of inputs, predict the post-edge state, then compare.
  task automatic step(input logic ld, input logic ic, input logic cl,
                      input logic pu, input logic po, input logic [15:0] din);
    exp_t        e;
    logic [15:0] ret;
    @(negedge clk);
    load = ld; inc = ic; clear = cl; push = pu; pop = po; in = din;
    ret   = m_pc + 16'd1;
    e.hit = !cl && watch_en && (m_pc == watch_addr);
    if (cl) begin
      m_pc = '0; m_sp = 0; m_err = 1'b0;
    end else begin
      if ((pu && po) || (pu && m_sp == 4) || (po && m_sp == 0)) m_err = 1'b1;
      if (po && !pu && m_sp > 0) begin
        m_sp = m_sp - 1;
        m_pc = m_stk[m_sp];
      end else if (ld) m_pc = din;
      else if (ic)     m_pc = ret;
      if (pu && !po && m_sp < 4) begin
        m_stk[m_sp] = ret;
        m_sp = m_sp + 1;
      end
    end
    e.pc  = m_pc;
    e.sp  = 3'(m_sp);
    e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("out", 32'(out), 32'(e.pc));
    check("sp_depth", 32'(sp_depth), 32'(e.sp));
    check("stack_err", 32'(stack_err), 32'(e.err));
    check("stack_full", 32'(stack_full), 32'(e.sp == 3'd4));
    check("stack_empty", 32'(stack_empty), 32'(e.sp == 3'd0));
`ifdef PC_WATCHPOINT_EN
    check("watch_hit", 32'(watch_hit), 32'(e.hit));
`endif
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_out", 32'(out), 32'h0);
    check("rst_sp", 32'(sp_depth), 32'h0);
    check("rst_err", 32'(stack_err), 32'h0);
    check("rst_empty", 32'(stack_empty), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // count from reset, then async reset between edges
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, '0);
    check("count3", 32'(out), 32'h3);
    #2 rst = 1'b1;
    #1 check("async_rst_out", 32'(out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // jump and wrap
    step(1, 0, 0, 0, 0, 16'hFFFE);
    step(0, 1, 0, 0, 0, '0);
    check("pre_wrap", 32'(out), 32'hFFFF);
    step(0, 1, 0, 0, 0, '0);
    check("wrap", 32'(out), 32'h0);

    // call / return
    step(1, 0, 0, 0, 0, 16'h0010);
    step(1, 0, 0, 1, 0, 16'h0200);
    check("call_sp", 32'(sp_depth), 32'h1);
    step(0, 1, 0, 0, 0, '0);
    step(0, 1, 0, 0, 0, '0);
    check("callee", 32'(out), 32'h0202);
    step(0, 0, 0, 0, 1, '0);
    check("ret_addr", 32'(out), 32'h0011);

    // overflow
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0, 0, 16'(i * 16'h0100));
      step(1, 0, 0, 1, 0, 16'h2000);
    end
    check("full", 32'(stack_full), 32'h1);
    step(0, 0, 0, 1, 0, '0);
    check("ovf_err", 32'(stack_err), 32'h1);
    check("ovf_sp", 32'(sp_depth), 32'h4);
    for (int i = 4; i >= 1; i--) begin
      step(0, 0, 0, 0, 1, '0);
      check("ovf_ret", 32'(out), 32'(i * 16'h0100 + 16'h0001));
    end

    // underflow and conflict
    step(0, 0, 1, 0, 0, '0);
    step(1, 0, 0, 0, 0, 16'h0050);
    step(0, 1, 0, 0, 1, '0);
    check("udf_out", 32'(out), 32'h0051);
    check("udf_err", 32'(stack_err), 32'h1);
    step(0, 0, 1, 0, 0, '0);
    step(1, 0, 0, 1, 1, 16'h1234);
    check("conf_out", 32'(out), 32'h1234);
    check("conf_err", 32'(stack_err), 32'h1);

    // clear precedence
    step(0, 0, 1, 0, 0, '0);
    step(1, 0, 0, 1, 0, 16'h0300);
    step(1, 0, 0, 1, 0, 16'h0400);
    step(1, 0, 1, 0, 1, 16'h7777);
    check("clr_out", 32'(out), 32'h0);
    check("clr_sp", 32'(sp_depth), 32'h0);

    // watchpoint scan from 0
    watch_addr = 16'h0003;
    watch_en   = 1'b1;
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, '0);
    watch_en = 1'b0;

    // random mix
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
